// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with register-file writeback.
// Shift-add multiply and restoring divide, one bit per cycle, signs applied on completion.
module mul_div_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result_hi,
  output logic [WIDTH-1:0]  result_lo,
  output logic              wb_enable,
  output logic [ADDR_W-1:0] wb_add,
  output logic [WIDTH-1:0]  wb_data
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  hi_q, lo_q, opnd_q;
  logic              is_div_q, neg_q, neg_rem_q;
  logic [ADDR_W-1:0] dest_q;

  // Capture-time decode
  logic             is_div_c, a_neg_c, b_neg_c, div_zero_c, last_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;

  assign is_div_c   = op[1];
  assign a_neg_c    = op[0] & a[WIDTH-1];
  assign b_neg_c    = op[0] & b[WIDTH-1];
  assign a_mag_c    = a_neg_c ? -a : a;
  assign b_mag_c    = b_neg_c ? -b : b;
  assign div_zero_c = is_div_c & (b == '0);
  assign last_c     = (cnt_q == CNT_W'(1));

  // One multiply step: add multiplicand on multiplier LSB, shift product right
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH-1:0] mul_hi_c, mul_lo_c;

  assign mul_sum_c = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_c  = mul_sum_c[WIDTH:1];
  assign mul_lo_c  = {mul_sum_c[0], lo_q[WIDTH-1:1]};

  // One restoring divide step: remainder in hi_q, dividend/quotient shifting through lo_q
  logic [WIDTH:0]   div_trial_c, div_diff_c;
  logic             div_ok_c;
  logic [WIDTH-1:0] div_hi_c, div_lo_c;

  assign div_trial_c = {hi_q, lo_q[WIDTH-1]};
  assign div_diff_c  = div_trial_c - {1'b0, opnd_q};
  assign div_ok_c    = ~div_diff_c[WIDTH];
  assign div_hi_c    = div_ok_c ? div_diff_c[WIDTH-1:0] : div_trial_c[WIDTH-1:0];
  assign div_lo_c    = {lo_q[WIDTH-2:0], div_ok_c};

  // Final signed results from the last step
  logic [2*WIDTH-1:0] prod_c, prod_s_c;
  logic [WIDTH-1:0]   fin_hi_c, fin_lo_c;

  assign prod_c   = {mul_hi_c, mul_lo_c};
  assign prod_s_c = neg_q ? -prod_c : prod_c;
  assign fin_hi_c = is_div_q ? (neg_rem_q ? -div_hi_c : div_hi_c) : prod_s_c[2*WIDTH-1:WIDTH];
  assign fin_lo_c = is_div_q ? (neg_q ? -div_lo_c : div_lo_c) : prod_s_c[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = div_zero_c ? DONE : RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dest_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wb_enable <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      wb_data   <= '0;
      wb_add    <= '0;
    end else begin
      done      <= 1'b0;
      wb_enable <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          busy      <= 1'b1;
          cnt_q     <= CNT_W'(WIDTH);
          is_div_q  <= is_div_c;
          neg_q     <= a_neg_c ^ b_neg_c;
          neg_rem_q <= is_div_c & a_neg_c;
          dest_q    <= dest;
          hi_q      <= '0;
          lo_q      <= is_div_c ? a_mag_c : b_mag_c;
          opnd_q    <= is_div_c ? b_mag_c : a_mag_c;
          if (div_zero_c) begin
            done      <= 1'b1;
            wb_enable <= (dest != {ADDR_W{1'b1}});
            result_hi <= a;
            result_lo <= '1;
            wb_data   <= '1;
            wb_add    <= dest;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          hi_q  <= is_div_q ? div_hi_c : mul_hi_c;
          lo_q  <= is_div_q ? div_lo_c : mul_lo_c;
          if (last_c) begin
            done      <= 1'b1;
            wb_enable <= (dest_q != {ADDR_W{1'b1}});
            result_hi <= fin_hi_c;
            result_lo <= fin_lo_c;
            wb_data   <= fin_lo_c;
            wb_add    <= dest_q;
          end
        end
        DONE:    busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand sequences, and
// randomized operations checked against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [4:0]  dest;
  logic        busy, done, wb_enable;
  logic [31:0] result_hi, result_lo, wb_data;
  logic [4:0]  wb_add;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .dest(dest),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .wb_enable(wb_enable), .wb_add(wb_add), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint      sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = {32'd0, x} * {32'd0, y}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = 64'(sx * sy); hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (y == 0) begin hi = x; lo = '1; end
        else begin lo = x / y; hi = x % y; end
      end
      default: begin
        if (y == 0) begin hi = x; lo = '1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin lo = x; hi = '0; end
        else begin lo = 32'(sx / sy); hi = 32'(sx % sy); end
      end
    endcase
  endfunction

  // Issue one op from a negedge in IDLE; scramble inputs after capture; check completion
  task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [4:0] dest_i, input logic [31:0] ehi, input logic [31:0] elo,
                        input int restart_at);
    int n;
    bit seen;
    int exp_lat;
    exp_lat = (op_i[1] && b_i == 0) ? 0 : 32;
    start = 1'b1; op = op_i; a = a_i; b = b_i; dest = dest_i;
    @(posedge clk);
    n = 0;
    seen = 0;
    while (n <= 40 && !seen) begin
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom); a = $urandom; b = $urandom; dest = 5'($urandom);
      if (done) seen = 1;
      else begin
        chk("busy_run", 64'(busy), 64'd1);
        if (n == restart_at) start = 1'b1;
        n++;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(n), 64'(exp_lat));
    chk("busy_done", 64'(busy), 64'd1);
    chk("result_hi", 64'(result_hi), 64'(ehi));
    chk("result_lo", 64'(result_lo), 64'(elo));
    chk("wb_data", 64'(wb_data), 64'(elo));
    chk("wb_add", 64'(wb_add), 64'(dest_i));
    chk("wb_enable", 64'(wb_enable), 64'(dest_i != 5'd31));
    @(negedge clk);
    chk("done_single", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("wb_en_idle", 64'(wb_enable), 64'd0);
    chk("hold_hi", 64'(result_hi), 64'(ehi));
    chk("hold_lo", 64'(result_lo), 64'(elo));
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] mhi, mlo;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [4:0]  rd;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd7,         5'd1,  32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{2'b10, 32'd100,       32'd0,         5'd4,  32'h0000_0064, 32'hFFFF_FFFF};
    vecs[5] = '{2'b00, 32'd2,         32'd3,         5'd31, 32'h0000_0000, 32'h0000_0006};
    vecs[6] = '{2'b10, 32'd100,       32'd7,         5'd9,  32'h0000_0002, 32'h0000_000E};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; dest = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wb_en", 64'(wb_enable), 64'd0);
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_lo", 64'(result_lo), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_add", 64'(wb_add), 64'd0);
    reset = 1'b0;

    // Directed table, first op issued on the first edge after reset release
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].hi, vecs[i].lo, -1);

    // Restart pulse mid-run must be ignored
    run_op(2'b00, 32'd3, 32'd4, 5'd7, 32'd0, 32'd12, 10);
    repeat (3) begin
      @(negedge clk);
      chk("no_extra_done", 64'(done), 64'd0);
      chk("no_extra_busy", 64'(busy), 64'd0);
    end

    // Reset at RUN cycle 16 aborts with no done or write
    start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0; dest = 5'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_wb_en", 64'(wb_enable), 64'd0);
    chk("abort_hi", 64'(result_hi), 64'd0);
    chk("abort_lo", 64'(result_lo), 64'd0);
    chk("abort_wb_data", 64'(wb_data), 64'd0);
    chk("abort_wb_add", 64'(wb_add), 64'd0);
    repeat (20) begin
      @(negedge clk);
      chk("abort_quiet", 64'({done, wb_enable}), 64'd0);
    end
    reset = 1'b0;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'd0, 32'd1, -1);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: ra = '1;
        2: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: rb = 32'd1;
        3: rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      rd = 5'($urandom_range(0, 31));
      model(ro, ra, rb, mhi, mlo);
      run_op(ro, ra, rb, rd, mhi, mlo, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
